// File: rtl/rom_dl_pkg.sv
// Shared types and constants for the ROM download sequencer.
// REGION_BASE follows the Ultra Tank ROM map.
package rom_dl_pkg;

    typedef enum logic [2:0] {
        BOOT = 3'd0,
        LOAD = 3'd1,
        HOLD = 3'd2,
        RUN  = 3'd3,
        RST  = 3'd4,
        ERR  = 3'd5
    } state_t;

    localparam int unsigned MAP_REGIONS = 4;

    // Index 0 is the program ROM; each region ends where the next one begins.
    localparam logic [MAP_REGIONS-1:0][15:0] REGION_BASE = {
        16'h2600,   // sync PROM
        16'h2400,   // motion objects
        16'h2000,   // playfield
        16'h0000    // program
    };

    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    localparam int unsigned CNT_W = cnt_width(1024, 16);

endpackage

// File: rtl/rom_rgn_decode.sv
// Combinational ROM region decoder: byte address to one-hot region select.
// The final region is bounded by the total ROM size.
module rom_rgn_decode
    import rom_dl_pkg::*;
#(
    parameter int unsigned NREG         = 4,
    parameter int unsigned EXPECT_BYTES = 10240
) (
    input  logic [24:0]     addr,
    output logic [NREG-1:0] sel
);

    logic [NREG:0][24:0] bound;

    always_comb begin
        bound = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            bound[i] = 25'(REGION_BASE[i]);
        end
        bound[NREG] = 25'(EXPECT_BYTES);

        sel = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            sel[i] = (addr >= bound[i]) && (addr < bound[i+1]);
        end
    end

endmodule

// File: rtl/rom_dl_sequencer.sv
// Bridges the ioctl ROM download bus to the core's dn_* port and sequences
// core reset around downloads and user reset requests.
module rom_dl_sequencer
    import rom_dl_pkg::*;
#(
    parameter int unsigned EXPECT_BYTES = 10240,
    parameter int unsigned POST_HOLD    = 1024,
    parameter int unsigned MIN_RST      = 16,
    parameter int unsigned NREG         = 4
) (
    input  logic            clk_sys,
    input  logic            reset,
    input  logic            ioctl_download,
    input  logic            ioctl_wr,
    input  logic [24:0]     ioctl_addr,
    input  logic [7:0]      ioctl_dout,
    input  logic            rst_req,
    output logic [15:0]     dn_addr,
    output logic [7:0]      dn_data,
    output logic            dn_wr,
    output logic [NREG-1:0] rgn_sel,
    output logic            core_reset,
    output logic            rom_ok,
    output logic            size_err,
    output logic [15:0]     byte_cnt
);

    localparam int unsigned CW = cnt_width(POST_HOLD, MIN_RST);

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            dl_prev, rst_prev, ovf;
    logic            dl_rise, dl_fall, in_range, accept, over_wr, cnt_zero;
    logic [NREG-1:0] rgn_dec;

    assign dl_rise  = ioctl_download & ~dl_prev;
    assign dl_fall  = ~ioctl_download & dl_prev;
    assign in_range = (ioctl_addr < 25'(EXPECT_BYTES));
    assign accept   = ioctl_wr & ioctl_download & in_range;
    assign over_wr  = ioctl_wr & ioctl_download & ~in_range;
    assign cnt_zero = (cnt == '0);

    rom_rgn_decode #(
        .NREG         (NREG),
        .EXPECT_BYTES (EXPECT_BYTES)
    ) u_rgn_decode (
        .addr (ioctl_addr),
        .sel  (rgn_dec)
    );

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state <= BOOT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (dl_rise) begin
            state_nxt = LOAD;
        end else begin
            case (state)
                LOAD: begin
                    if (dl_fall) begin
                        if (byte_cnt == 16'(EXPECT_BYTES) && !ovf) begin
                            state_nxt = HOLD;
                            cnt_nxt   = CW'(POST_HOLD - 1);
                        end else begin
                            state_nxt = ERR;
                        end
                    end
                end
                HOLD: begin
                    if (cnt_zero) state_nxt = RUN;
                    else          cnt_nxt   = cnt - 1'b1;
                end
                RUN: begin
                    if (rst_req) begin
                        state_nxt = RST;
                        cnt_nxt   = CW'(MIN_RST - 1);
                    end
                end
                RST: begin
                    // Release needs two consecutive low samples, so a held
                    // request is outlasted by one cycle.
                    if (!cnt_zero)                 cnt_nxt   = cnt - 1'b1;
                    else if (!rst_req && !rst_prev) state_nxt = RUN;
                end
                BOOT, ERR: ;
                default: state_nxt = BOOT;
            endcase
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            dl_prev    <= 1'b0;
            rst_prev   <= 1'b0;
            dn_wr      <= 1'b0;
            dn_addr    <= '0;
            dn_data    <= '0;
            rgn_sel    <= '0;
            core_reset <= 1'b1;
            byte_cnt   <= '0;
            ovf        <= 1'b0;
            rom_ok     <= 1'b0;
            size_err   <= 1'b0;
        end else begin
            dl_prev    <= ioctl_download;
            rst_prev   <= rst_req;
            dn_wr      <= accept;
            rgn_sel    <= accept ? rgn_dec : '0;
            core_reset <= (state_nxt != RUN);
            if (accept) begin
                dn_addr <= ioctl_addr[15:0];
                dn_data <= ioctl_dout;
            end
            if (dl_rise) begin
                // A write coinciding with the download edge still counts.
                byte_cnt <= accept ? 16'd1 : 16'd0;
                ovf      <= over_wr;
                rom_ok   <= 1'b0;
                size_err <= 1'b0;
            end else begin
                if (accept && byte_cnt != '1) byte_cnt <= byte_cnt + 16'd1;
                if (over_wr)                  ovf      <= 1'b1;
                if (state == LOAD && dl_fall) begin
                    if (state_nxt == HOLD) rom_ok   <= 1'b1;
                    else                   size_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rom_dl_sequencer.sv
// Scoreboarded random-stimulus bench for rom_dl_sequencer: forwarded writes
// are checked by a monitor, reset sequencing by the stimulus thread.
module tb_rom_dl_sequencer;

    localparam int unsigned EXPECT_BYTES = 10240;
    localparam int unsigned POST_HOLD    = 1024;
    localparam int unsigned MIN_RST      = 16;
    localparam int unsigned NREG         = 4;

    logic            clk_sys = 1'b0;
    logic            reset;
    logic            ioctl_download;
    logic            ioctl_wr;
    logic [24:0]     ioctl_addr;
    logic [7:0]      ioctl_dout;
    logic            rst_req;
    logic [15:0]     dn_addr;
    logic [7:0]      dn_data;
    logic            dn_wr;
    logic [NREG-1:0] rgn_sel;
    logic            core_reset;
    logic            rom_ok;
    logic            size_err;
    logic [15:0]     byte_cnt;

    rom_dl_sequencer #(
        .EXPECT_BYTES (EXPECT_BYTES),
        .POST_HOLD    (POST_HOLD),
        .MIN_RST      (MIN_RST),
        .NREG         (NREG)
    ) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .rst_req        (rst_req),
        .dn_addr        (dn_addr),
        .dn_data        (dn_data),
        .dn_wr          (dn_wr),
        .rgn_sel        (rgn_sel),
        .core_reset     (core_reset),
        .rom_ok         (rom_ok),
        .size_err       (size_err),
        .byte_cnt       (byte_cnt)
    );

    initial forever #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        logic [3:0]  r;
        longint      c;
    } exp_t;

    exp_t   sb[$];
    longint cyc = 0;
    int     errors = 0;
    int     checks = 0;

    always @(posedge clk_sys) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] ref_region(input int unsigned a);
        if (a < 'h2000)      return 4'b0001;
        else if (a < 'h2400) return 4'b0010;
        else if (a < 'h2600) return 4'b0100;
        else                 return 4'b1000;
    endfunction

    always @(negedge clk_sys) begin
        if (!reset) begin
            if (dn_wr) begin
                if (sb.size() == 0) begin
                    check("unexpected_dn_wr", {16'h0, dn_addr}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("dn_addr_data_rgn", {4'h0, dn_addr, dn_data, rgn_sel},
                          {4'h0, e.a, e.d, e.r});
                    check("dn_latency", 32'(cyc - e.c), 32'd1);
                end
            end else begin
                check("rgn_sel_idle", 32'(rgn_sel), 32'd0);
            end
        end
    end

    task automatic tick;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic start_dl;
        ioctl_download = 1'b1;
        tick;
    endtask

    task automatic end_dl;
        ioctl_download = 1'b0;
        tick;
    endtask

    task automatic write_bytes(input int unsigned n, input bit rand_data, input bit extra_ovf);
        int unsigned total;
        total = extra_ovf ? n + 1 : n;
        for (int unsigned i = 0; i < total; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                ioctl_wr = 1'b0;
                tick;
            end
            ioctl_wr   = 1'b1;
            ioctl_addr = 25'(i);
            ioctl_dout = rand_data ? 8'($urandom) : 8'(i);
            if (i < EXPECT_BYTES) begin
                exp_t e;
                e.a = 16'(i);
                e.d = ioctl_dout;
                e.r = ref_region(i);
                e.c = cyc;
                sb.push_back(e);
            end
            tick;
        end
        ioctl_wr = 1'b0;
        tick;
        tick;
    endtask

    task automatic measure_release(input string name, input int unsigned exp_cycles);
        int unsigned n;
        n = 0;
        while (core_reset && n < 3000) begin
            tick;
            n++;
        end
        check(name, n, exp_cycles);
    endtask

    task automatic user_reset(input int unsigned hold);
        int unsigned w;
        int unsigned expw;
        rst_req = 1'b1;
        tick;
        check("rst_assert", 32'(core_reset), 32'd1);
        w = 0;
        while (core_reset && w < 200) begin
            if (w == hold - 1) rst_req = 1'b0;
            tick;
            w++;
        end
        rst_req = 1'b0;
        expw = (hold + 1 > MIN_RST) ? hold + 1 : MIN_RST;
        check("rst_pulse_width", w, expw);
        repeat (3) tick;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_core_reset"}, 32'(core_reset), 32'd1);
        check({tag, "_rom_ok"}, 32'(rom_ok), 32'd0);
        check({tag, "_size_err"}, 32'(size_err), 32'd0);
        check({tag, "_dn_wr"}, 32'(dn_wr), 32'd0);
        check({tag, "_dn_addr"}, 32'(dn_addr), 32'd0);
        check({tag, "_dn_data"}, 32'(dn_data), 32'd0);
        check({tag, "_rgn_sel"}, 32'(rgn_sel), 32'd0);
        check({tag, "_byte_cnt"}, 32'(byte_cnt), 32'd0);
    endtask

    initial begin
        int unsigned lows;
        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        rst_req        = 1'b0;
        #1;
        check_reset_values("por");
        repeat (3) tick;
        reset = 1'b0;

        // rst_req before any download must not release the core
        rst_req = 1'b1;
        repeat (20) tick;
        check("boot_ignores_rst_req", 32'(core_reset), 32'd1);
        rst_req = 1'b0;
        tick;

        // good load with data = addr[7:0]
        start_dl;
        check("load1_core_reset", 32'(core_reset), 32'd1);
        write_bytes(EXPECT_BYTES, 1'b0, 1'b0);
        check("load1_byte_cnt", 32'(byte_cnt), EXPECT_BYTES);
        end_dl;
        check("load1_rom_ok", 32'(rom_ok), 32'd1);
        check("load1_size_err", 32'(size_err), 32'd0);
        measure_release("load1_hold", POST_HOLD);

        // user reset requests in RUN
        repeat (5) tick;
        user_reset(1);
        user_reset(40);
        repeat (3) user_reset($urandom_range(1, 30));

        // re-download from RUN, short by one byte
        start_dl;
        check("redl_core_reset", 32'(core_reset), 32'd1);
        check("redl_byte_cnt", 32'(byte_cnt), 32'd0);
        check("redl_rom_ok", 32'(rom_ok), 32'd0);
        write_bytes(EXPECT_BYTES - 1, 1'b1, 1'b0);
        end_dl;
        check("short_size_err", 32'(size_err), 32'd1);
        check("short_rom_ok", 32'(rom_ok), 32'd0);
        lows = 0;
        for (int unsigned i = 0; i < 5000; i++) begin
            rst_req = 1'($urandom);
            tick;
            if (!core_reset) lows++;
        end
        rst_req = 1'b0;
        check("err_core_reset_low_cycles", lows, 32'd0);
        check("err_size_err_held", 32'(size_err), 32'd1);

        // good load after an error
        start_dl;
        check("reload_size_err_cleared", 32'(size_err), 32'd0);
        write_bytes(EXPECT_BYTES, 1'b1, 1'b0);
        end_dl;
        check("reload_rom_ok", 32'(rom_ok), 32'd1);
        check("reload_size_err", 32'(size_err), 32'd0);
        measure_release("reload_hold", POST_HOLD);
        check("reload_run", 32'(core_reset), 32'd0);

        // full load plus one write past the end
        start_dl;
        write_bytes(EXPECT_BYTES, 1'b1, 1'b1);
        check("ovf_byte_cnt", 32'(byte_cnt), EXPECT_BYTES);
        end_dl;
        check("ovf_size_err", 32'(size_err), 32'd1);
        check("ovf_rom_ok", 32'(rom_ok), 32'd0);
        repeat (20) tick;
        check("ovf_core_reset", 32'(core_reset), 32'd1);

        // new download out of ERR, aborted by async reset
        start_dl;
        check("partial_size_err_cleared", 32'(size_err), 32'd0);
        write_bytes(500, 1'b1, 1'b0);
        check("partial_byte_cnt", 32'(byte_cnt), 32'd500);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("async");
        ioctl_download = 1'b0;
        repeat (2) tick;
        reset = 1'b0;
        lows = 0;
        for (int unsigned i = 0; i < 50; i++) begin
            rst_req = 1'($urandom);
            tick;
            if (!core_reset) lows++;
        end
        rst_req = 1'b0;
        check("post_reset_boot_low_cycles", lows, 32'd0);
        check("post_reset_byte_cnt", 32'(byte_cnt), 32'd0);
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rom_dl_sequencer.md
Name: rom_dl_sequencer

Overview:
- Sits between hps_io's ioctl download bus and the Ultra Tank core in the emu top level.
- Forwards downloaded ROM bytes to the core's dn_* port through one register stage, and decodes a one-hot ROM region select.
- Counts and validates the received bytes.
- Sequences core reset: the core is held in reset during download, for a flush interval after it, and for a minimum pulse on any user reset request. It is never released after a bad-size download.

Parameters:
- EXPECT_BYTES, 10240: exact byte count of a valid ROM set; writes at or above this address are dropped.
- POST_HOLD, 1024: clk_sys cycles the core stays in reset after a good download ends.
- MIN_RST, 16: minimum clk_sys cycles of core reset for a user reset request.
- NREG, 4: number of ROM regions decoded for rgn_sel.

Ports:
- clk_sys  in  1  system clock (12 MHz); only clock in the block.
- reset  in  1  asynchronous, active-high reset.
- ioctl_download  in  1  download in progress.
- ioctl_wr  in  1  byte write strobe, one cycle.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- rst_req  in  1  user reset request, level (status[0] | buttons[1]).
- dn_addr  out  16  registered write address to core.
- dn_data  out  8  registered write data.
- dn_wr  out  1  registered write strobe.
- rgn_sel  out  NREG  one-hot region of the current dn_addr; all zero when dn_wr=0.
- core_reset  out  1  active-high; the top level drives Reset_n = ~core_reset.
- rom_ok  out  1  last download complete and correctly sized.
- size_err  out  1  last download wrong size or overflowed.
- byte_cnt  out  16  accepted bytes in the current or last download, saturating at 16'hFFFF.

Behaviour:

Reset values:
- core_reset=1, rom_ok=0, size_err=0.
- dn_wr=0, dn_addr=0, dn_data=0, rgn_sel=0, byte_cnt=0.
- State = BOOT.

Write path (latency 1):
- A write is accepted when ioctl_wr & ioctl_download & ioctl_addr < EXPECT_BYTES.
- The cycle after acceptance: dn_wr=1, dn_addr=ioctl_addr[15:0], dn_data=ioctl_dout, rgn_sel=decode(ioctl_addr).
- Otherwise dn_wr=0 and rgn_sel=0; dn_addr and dn_data hold their values.
- Write with ioctl_addr >= EXPECT_BYTES: not forwarded, sets an internal ovf flag.
- byte_cnt increments by 1 per accepted write.

Region decode:
- Region i is selected when REGION_BASE[i] <= addr < REGION_BASE[i+1].
- The last region ends at EXPECT_BYTES.

States:
- BOOT: core_reset=1.
  - Rising edge of ioctl_download -> LOAD.
  - rst_req is ignored.
- LOAD: core_reset=1.
  - On entry: byte_cnt=0, ovf=0, rom_ok=0, size_err=0.
  - On the falling edge of ioctl_download:
    - if byte_cnt==EXPECT_BYTES and ovf=0 -> HOLD, counter=POST_HOLD-1, rom_ok=1;
    - else -> ERR, size_err=1.
- HOLD: core_reset=1; the counter decrements each cycle.
  - At counter==0 -> RUN; core_reset=0 from the following cycle.
- RUN: core_reset=0.
  - rst_req=1 -> RST, counter=MIN_RST-1.
- RST: core_reset=1.
  - Leaves when counter==0 and rst_req==0 -> RUN.
  - The pulse is therefore >= MIN_RST cycles and extends while rst_req is held.
- ERR: core_reset=1, size_err=1. Only a new download (rising edge of ioctl_download) exits, to LOAD.

Priority and boundaries:
- A rising edge of ioctl_download from any state goes to LOAD; this has the highest priority.
  - Applies mid-HOLD and mid-RST.
  - In RUN the core is asserted back into reset on the next cycle.
- rst_req in LOAD, HOLD or ERR has no effect.
- The edge detectors use the registered previous value of ioctl_download.
  - A download asserted at the first cycle after reset deassert counts as a rising edge, since the previous value resets to 0.
- Asynchronous reset mid-download: everything returns to the reset values; the partial ROM load must be redone.
- byte_cnt saturates and never wraps.
- ioctl_addr bits above 15 are ignored for dn_addr but included in the bound check.

Decomposition:
- Package rom_dl_pkg holds:
  - the state enum (BOOT, LOAD, HOLD, RUN, RST, ERR);
  - the REGION_BASE constant array (Ultra Tank map: 0x0000 program, 0x2000 playfield, 0x2400 motion objects, 0x2600 sync PROM);
  - the counter width constant (clog2 of max(POST_HOLD, MIN_RST)).
- One sub-module, rom_rgn_decode: combinational address -> one-hot rgn_sel. Everything else stays in rom_dl_sequencer.

Test Plan:
- Good load: assert ioctl_download and write 10240 bytes, addr 0..10239, data=addr[7:0], then deassert.
  - Each dn_wr is 1 cycle after its ioctl_wr with matching addr and data.
  - rgn_sel is 4'b0001 at 0x1FFF and 4'b0010 at 0x2000.
  - byte_cnt=10240 and rom_ok=1.
  - core_reset falls exactly 1024 cycles after the download falling edge.
- Short load: 10239 bytes -> ERR, size_err=1, rom_ok=0, core_reset stays 1 for 5000 cycles.
  - A subsequent good load clears size_err and reaches RUN.
- Overflow: good load plus one write at addr 10240 -> no dn_wr for that write; size_err=1.
- User reset in RUN:
  - rst_req pulsed for 1 cycle -> core_reset high for exactly 16 cycles.
  - rst_req held for 40 cycles -> core_reset high for 41 cycles.
- Re-download during RUN: rising edge of ioctl_download -> core_reset=1 the next cycle, byte_cnt=0, rom_ok=0.
- Async reset mid-LOAD after 500 bytes: all outputs return to reset values immediately; state is BOOT, and rst_req is ignored until a new download.
